// File: rtl/pipe_pkg.sv
// Shared types and widths for the MEM/WB skid stage.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  en;
    logic [WORD_W-1:0]     data;
    logic                  hilo_en;
    logic [WORD_W-1:0]     hi;
    logic [WORD_W-1:0]     lo;
  } wb_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One writeback bundle register with load enable; HI/LO fields vanish when HILO_EN=0.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W  = WORD_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter bit HILO_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_en,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_hilo_en,
  input  logic [DATA_W-1:0] d_hi,
  input  logic [DATA_W-1:0] d_lo,
  output logic [ADDR_W-1:0] q_addr,
  output logic              q_en,
  output logic [DATA_W-1:0] q_data,
  output logic              q_hilo_en,
  output logic [DATA_W-1:0] q_hi,
  output logic [DATA_W-1:0] q_lo
);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_addr <= '0;
      q_en   <= 1'b0;
      q_data <= '0;
    end else if (load) begin
      q_addr <= d_addr;
      q_en   <= d_en;
      q_data <= d_data;
    end
  end

  if (HILO_EN) begin : g_hilo
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        q_hilo_en <= 1'b0;
        q_hi      <= '0;
        q_lo      <= '0;
      end else if (load) begin
        q_hilo_en <= d_hilo_en;
        q_hi      <= d_hi;
        q_lo      <= d_lo;
      end
    end
  end else begin : g_no_hilo
    logic unused_hilo;
    assign unused_hilo = ^{d_hilo_en, d_hi, d_lo};
    assign q_hilo_en   = 1'b0;
    assign q_hi        = '0;
    assign q_lo        = '0;
  end

endmodule

// File: rtl/pipe_wb_skid.sv
// MEM/WB stage with valid/ready handshake, one-entry skid buffer and flush.
module pipe_wb_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = WORD_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter bit HILO_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_hilo_en,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pipe_mem_addr,
  output logic              pipe_mem_en,
  output logic [DATA_W-1:0] pipe_mem_data,
  output logic              pipe_hilo_en,
  output logic [DATA_W-1:0] pipe_hi,
  output logic [DATA_W-1:0] pipe_lo,
  output logic              skid_full
);

  skid_state_t state_q, state_d;
  logic accept, consume;
  logic main_load, skid_load, main_from_skid;

  logic [ADDR_W-1:0] main_addr, skid_addr, main_d_addr;
  logic              main_en, skid_en, main_d_en;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic              main_hilo_en, skid_hilo_en, main_d_hilo_en;
  logic [DATA_W-1:0] main_hi, skid_hi, main_d_hi;
  logic [DATA_W-1:0] main_lo, skid_lo, main_d_lo;

  // Handshake flags decode registered state only; out_ready never reaches in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign skid_full = (state_q == FULL);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
        BUSY: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: if (consume) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  assign main_d_addr    = main_from_skid ? skid_addr    : mem_addr;
  assign main_d_en      = main_from_skid ? skid_en      : mem_en;
  assign main_d_data    = main_from_skid ? skid_data    : mem_data;
  assign main_d_hilo_en = main_from_skid ? skid_hilo_en : mem_hilo_en;
  assign main_d_hi      = main_from_skid ? skid_hi      : mem_hi;
  assign main_d_lo      = main_from_skid ? skid_lo      : mem_lo;

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HILO_EN(HILO_EN)) u_main (
    .clk(clk), .reset(reset), .load(main_load),
    .d_addr(main_d_addr), .d_en(main_d_en), .d_data(main_d_data),
    .d_hilo_en(main_d_hilo_en), .d_hi(main_d_hi), .d_lo(main_d_lo),
    .q_addr(main_addr), .q_en(main_en), .q_data(main_data),
    .q_hilo_en(main_hilo_en), .q_hi(main_hi), .q_lo(main_lo)
  );

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HILO_EN(HILO_EN)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load),
    .d_addr(mem_addr), .d_en(mem_en), .d_data(mem_data),
    .d_hilo_en(mem_hilo_en), .d_hi(mem_hi), .d_lo(mem_lo),
    .q_addr(skid_addr), .q_en(skid_en), .q_data(skid_data),
    .q_hilo_en(skid_hilo_en), .q_hi(skid_hi), .q_lo(skid_lo)
  );

  // A bubble must never write the register file or HI/LO.
  assign pipe_mem_addr = main_addr;
  assign pipe_mem_data = main_data;
  assign pipe_mem_en   = main_en & out_valid;
  assign pipe_hilo_en  = main_hilo_en & out_valid & HILO_EN;
  assign pipe_hi       = main_hi;
  assign pipe_lo       = main_lo;

endmodule

// File: tb/tb_pipe_wb_skid.sv
// Scoreboard bench for pipe_wb_skid: directed bundles, monitor pops on every consume.
module tb_pipe_wb_skid;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic        mem_en = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_hilo_en = 1'b0;
  logic [31:0] mem_hi = '0;
  logic [31:0] mem_lo = '0;

  logic        in_ready, out_valid, pipe_mem_en, pipe_hilo_en, skid_full;
  logic [4:0]  pipe_mem_addr;
  logic [31:0] pipe_mem_data, pipe_hi, pipe_lo;

  logic        nh_in_ready, nh_out_valid, nh_mem_en, nh_hilo_en, nh_skid_full;
  logic [4:0]  nh_addr;
  logic [31:0] nh_data, nh_hi, nh_lo;

  int checks = 0;
  int errors = 0;
  wb_bundle_t exp_q[$];

  always #5 clk = ~clk;

  pipe_wb_skid #(.DATA_W(32), .ADDR_W(5), .HILO_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .mem_hilo_en(mem_hilo_en), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .pipe_mem_addr(pipe_mem_addr), .pipe_mem_en(pipe_mem_en), .pipe_mem_data(pipe_mem_data),
    .pipe_hilo_en(pipe_hilo_en), .pipe_hi(pipe_hi), .pipe_lo(pipe_lo), .skid_full(skid_full)
  );

  pipe_wb_skid #(.DATA_W(32), .ADDR_W(5), .HILO_EN(1'b0)) dut_nohilo (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nh_in_ready),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .mem_hilo_en(mem_hilo_en), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .out_valid(nh_out_valid), .out_ready(out_ready),
    .pipe_mem_addr(nh_addr), .pipe_mem_en(nh_mem_en), .pipe_mem_data(nh_data),
    .pipe_hilo_en(nh_hilo_en), .pipe_hi(nh_hi), .pipe_lo(nh_lo), .skid_full(nh_skid_full)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic wb_bundle_t mk(input logic [4:0] a, input logic e, input logic [31:0] d,
                                    input logic he, input logic [31:0] h, input logic [31:0] l);
    wb_bundle_t b;
    b.addr = a; b.en = e; b.data = d; b.hilo_en = he; b.hi = h; b.lo = l;
    return b;
  endfunction

  task automatic drive(input wb_bundle_t b, input logic v);
    in_valid    = v;
    mem_addr    = b.addr;
    mem_en      = b.en;
    mem_data    = b.data;
    mem_hilo_en = b.hilo_en;
    mem_hi      = b.hi;
    mem_lo      = b.lo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a consume happens at the next edge whenever valid and ready are both high.
  initial begin
    wb_bundle_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {59'd0, pipe_mem_addr}, 64'h3f);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", {59'd0, pipe_mem_addr}, {59'd0, e.addr});
          check("out_data", {32'd0, pipe_mem_data}, {32'd0, e.data});
          check("out_en", {63'd0, pipe_mem_en}, {63'd0, e.en});
          check("out_hilo_en", {63'd0, pipe_hilo_en}, {63'd0, e.hilo_en});
          check("out_hilo", {pipe_hi, pipe_lo}, {e.hi, e.lo});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_bundle_t a, b, c, z;
    z = mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_skid_full", {63'd0, skid_full}, 64'd0);
    check("rst_outputs", {pipe_mem_addr, pipe_mem_en, pipe_hilo_en, pipe_mem_data}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Streaming at full rate
    out_ready = 1'b1;
    a = mk(5'd3, 1'b1, 32'h11111111, 1'b0, 32'h0, 32'h0);
    b = mk(5'd4, 1'b1, 32'h22222222, 1'b0, 32'h0, 32'h0);
    drive(a, 1'b1); exp_q.push_back(a);
    check("stream_ready0", {63'd0, in_ready}, 64'd1);
    tick();
    check("stream_valid0", {63'd0, out_valid}, 64'd1);
    drive(b, 1'b1); exp_q.push_back(b);
    check("stream_ready1", {63'd0, in_ready}, 64'd1);
    tick();
    check("stream_addr1", {59'd0, pipe_mem_addr}, 64'd4);
    drive(z, 1'b0);
    tick();

    // Bubble gating: main still holds en=1/addr=4 but nothing is valid
    check("bubble_valid", {63'd0, out_valid}, 64'd0);
    check("bubble_en", {63'd0, pipe_mem_en}, 64'd0);
    check("bubble_addr", {59'd0, pipe_mem_addr}, 64'd4);

    // Stall into skid
    out_ready = 1'b0;
    a = mk(5'd5, 1'b1, 32'hA, 1'b0, 32'h0, 32'h0);
    b = mk(5'd6, 1'b1, 32'hB, 1'b0, 32'h0, 32'h0);
    c = mk(5'd7, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    drive(a, 1'b1); exp_q.push_back(a);
    tick();
    check("stall_ready_busy", {63'd0, in_ready}, 64'd1);
    drive(b, 1'b1); exp_q.push_back(b);
    tick();
    check("stall_ready_full", {63'd0, in_ready}, 64'd0);
    check("stall_skid_full", {63'd0, skid_full}, 64'd1);
    check("stall_shows_a", {27'd0, pipe_mem_addr, pipe_mem_data}, {27'd0, 5'd5, 32'hA});
    drive(c, 1'b1);
    tick();
    check("full_ignores_c", {27'd0, pipe_mem_addr, pipe_mem_data}, {27'd0, 5'd5, 32'hA});
    check("full_holds", {63'd0, skid_full}, 64'd1);
    drive(z, 1'b0);
    out_ready = 1'b1;
    tick();
    check("release_ready", {63'd0, in_ready}, 64'd1);
    check("release_shows_b", {59'd0, pipe_mem_addr}, 64'd6);
    tick();
    check("release_empty", {63'd0, out_valid}, 64'd0);
    drive(c, 1'b1); exp_q.push_back(c);
    tick();
    drive(z, 1'b0);
    tick();

    // Flush while FULL, with a bundle offered in the same cycle
    out_ready = 1'b0;
    a = mk(5'd10, 1'b1, 32'hAAAA0001, 1'b1, 32'h1, 32'h2);
    b = mk(5'd11, 1'b1, 32'hBBBB0002, 1'b1, 32'h3, 32'h4);
    drive(a, 1'b1); exp_q.push_back(a);
    tick();
    drive(b, 1'b1); exp_q.push_back(b);
    tick();
    drive(mk(5'd12, 1'b1, 32'hCCCC0003, 1'b1, 32'h5, 32'h6), 1'b1);
    flush = 1'b1;
    check("flush_ready_pre", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    drive(z, 1'b0);
    exp_q.delete();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_en", {63'd0, pipe_mem_en}, 64'd0);
    check("flush_hilo_en", {63'd0, pipe_hilo_en}, 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    check("flush_skid", {63'd0, skid_full}, 64'd0);
    out_ready = 1'b1;
    tick();
    tick();

    // HI/LO carried, and pruned in the HILO_EN=0 build
    out_ready = 1'b0;
    a = mk(5'd9, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 32'h12345678);
    drive(a, 1'b1); exp_q.push_back(a);
    tick();
    drive(z, 1'b0);
    check("hilo_en", {63'd0, pipe_hilo_en}, 64'd1);
    check("hilo_vals", {pipe_hi, pipe_lo}, 64'hDEADBEEF_12345678);
    check("nohilo_valid", {63'd0, nh_out_valid}, 64'd1);
    check("nohilo_en", {63'd0, nh_hilo_en}, 64'd0);
    check("nohilo_vals", {nh_hi, nh_lo}, 64'd0);
    out_ready = 1'b1;
    tick();

    // Back-to-back throughput
    for (int i = 0; i < 4; i++) begin
      a = mk(5'(16 + i), 1'(i % 2), 32'h1000 + 32'(i), 1'b0, 32'h0, 32'h0);
      drive(a, 1'b1); exp_q.push_back(a);
      check("thru_ready", {63'd0, in_ready}, 64'd1);
      tick();
    end
    drive(z, 1'b0);
    tick();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    a = mk(5'd20, 1'b1, 32'h55, 1'b1, 32'h7, 32'h8);
    b = mk(5'd21, 1'b1, 32'h66, 1'b1, 32'h9, 32'hA);
    drive(a, 1'b1); exp_q.push_back(a);
    tick();
    drive(b, 1'b1); exp_q.push_back(b);
    tick();
    drive(z, 1'b0);
    check("prereset_full", {63'd0, skid_full}, 64'd1);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_skid", {63'd0, skid_full}, 64'd0);
    check("arst_outputs", {pipe_mem_addr, pipe_mem_en, pipe_hilo_en, pipe_mem_data}, 64'd0);
    check("arst_hilo", {pipe_hi, pipe_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    a = mk(5'd22, 1'b1, 32'h77, 1'b0, 32'h0, 32'h0);
    drive(a, 1'b1); exp_q.push_back(a);
    tick();
    drive(z, 1'b0);
    check("post_reset_accept", {63'd0, out_valid}, 64'd1);

    // Drain, bounded
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
